// File: rtl/etapa_if.sv
// Instruction-fetch stage: drives the instruction-memory handshake, keeps a one-entry skid buffer for stalls, and handles branch redirects.
// Optional halt-on-all-ones detection is enabled by defining IF_HALT_DET_EN.
module etapa_if #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INSTR_W  = 14,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_in,
    input  logic               branch_taken_in,
    input  logic [PC_W-1:0]    branch_target_in,
    output logic               imem_rd_out,
    output logic [PC_W-1:0]    imem_addr_out,
    input  logic [INSTR_W-1:0] imem_data_in,
    input  logic               imem_ready_in,
    output logic [INSTR_W-1:0] instruction_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               valid_out,
    output logic               halt_out
);

    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

`ifdef IF_HALT_DET_EN
    typedef enum logic [1:0] {FETCH = 2'd0, SKID = 2'd1, HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {FETCH = 2'd0, SKID = 2'd1} state_t;
`endif

    state_t             r_state, w_state;
    logic [PC_W-1:0]    r_pc, w_pc;
    logic [INSTR_W-1:0] r_instr, w_instr;
    logic [PC_W-1:0]    r_pc_out, w_pc_out;
    logic               r_valid, w_valid;
    logic [INSTR_W-1:0] r_skid_instr, w_skid_instr;
    logic [PC_W-1:0]    r_skid_pc, w_skid_pc;
    logic               w_xfer;

    // Request is gated by reset so an in-flight read is abandoned asynchronously.
    assign imem_rd_out     = (r_state == FETCH) && !reset;
    assign imem_addr_out   = r_pc;
    assign w_xfer          = imem_rd_out && imem_ready_in;
    assign instruction_out = r_instr;
    assign pc_out          = r_pc_out;
    assign valid_out       = r_valid;

`ifdef IF_HALT_DET_EN
    assign halt_out = (r_state == HALT);
`else
    assign halt_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= FETCH;
            r_pc         <= PC_RST;
            r_instr      <= '0;
            r_pc_out     <= '0;
            r_valid      <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else begin
            r_state      <= w_state;
            r_pc         <= w_pc;
            r_instr      <= w_instr;
            r_pc_out     <= w_pc_out;
            r_valid      <= w_valid;
            r_skid_instr <= w_skid_instr;
            r_skid_pc    <= w_skid_pc;
        end
    end

    // Branch outranks stall and transfer; stall freezes the outputs otherwise.
    always_comb begin
        w_state      = r_state;
        w_pc         = r_pc;
        w_instr      = r_instr;
        w_pc_out     = r_pc_out;
        w_valid      = r_valid;
        w_skid_instr = r_skid_instr;
        w_skid_pc    = r_skid_pc;
        case (r_state)
            FETCH: begin
                if (branch_taken_in) begin
                    w_pc    = branch_target_in;
                    w_valid = 1'b0;
                end else if (w_xfer && !stall_in) begin
                    w_instr  = imem_data_in;
                    w_pc_out = r_pc;
                    w_valid  = 1'b1;
                    w_pc     = r_pc + PC_W'(1);
`ifdef IF_HALT_DET_EN
                    if (&imem_data_in) w_state = HALT;
`endif
                end else if (w_xfer) begin
                    w_skid_instr = imem_data_in;
                    w_skid_pc    = r_pc;
                    w_pc         = r_pc + PC_W'(1);
                    w_state      = SKID;
                end else if (!stall_in) begin
                    w_valid = 1'b0;
                end
            end
            SKID: begin
                if (branch_taken_in) begin
                    w_pc    = branch_target_in;
                    w_valid = 1'b0;
                    w_state = FETCH;
                end else if (!stall_in) begin
                    w_instr  = r_skid_instr;
                    w_pc_out = r_skid_pc;
                    w_valid  = 1'b1;
                    w_state  = FETCH;
`ifdef IF_HALT_DET_EN
                    if (&r_skid_instr) w_state = HALT;
`endif
                end
            end
`ifdef IF_HALT_DET_EN
            HALT: begin
                // The halting instruction is presented once, then bubbles.
                if (!stall_in) w_valid = 1'b0;
            end
`endif
            default: w_state = FETCH;
        endcase
    end

endmodule

// File: tb/tb_etapa_if.sv
// Directed self-checking bench for etapa_if; memory returns addr+14'h100 except an optional all-ones word at address 3.
module tb_etapa_if;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        branch_taken_in;
    logic [7:0]  branch_target_in;
    logic        imem_rd_out;
    logic [7:0]  imem_addr_out;
    logic [13:0] imem_data_in;
    logic        imem_ready_in;
    logic [13:0] instruction_out;
    logic [7:0]  pc_out;
    logic        valid_out;
    logic        halt_out;
    logic        halt_word;

    int n_vec = 0;
    int n_err = 0;

    etapa_if dut (
        .clk              (clk),
        .reset            (reset),
        .stall_in         (stall_in),
        .branch_taken_in  (branch_taken_in),
        .branch_target_in (branch_target_in),
        .imem_rd_out      (imem_rd_out),
        .imem_addr_out    (imem_addr_out),
        .imem_data_in     (imem_data_in),
        .imem_ready_in    (imem_ready_in),
        .instruction_out  (instruction_out),
        .pc_out           (pc_out),
        .valid_out        (valid_out),
        .halt_out         (halt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data_in = (halt_word && imem_addr_out == 8'd3) ? 14'h3FFF
                                                               : 14'(imem_addr_out) + 14'h100;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall_in = 1'b0; branch_taken_in = 1'b0;
        branch_target_in = 8'h00; imem_ready_in = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall_in = 1'b0; branch_taken_in = 1'b0;
        branch_target_in = 8'h00; imem_ready_in = 1'b1; halt_word = 1'b0;
        cyc(2);
        n_vec++;
        if ({imem_rd_out, valid_out, halt_out, pc_out, instruction_out, imem_addr_out} !== {3'b000, 8'h00, 14'h0000, 8'h00}) begin
            n_err++;
            $display("FAIL reset_state got rd/v/h=%b%b%b pc_out=%h instr=%h addr=%h want 000 00 0000 00",
                     imem_rd_out, valid_out, halt_out, pc_out, instruction_out, imem_addr_out);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if ({imem_rd_out, imem_addr_out} !== {1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL first_request got rd=%b addr=%h want rd=1 addr=00", imem_rd_out, imem_addr_out);
        end
        cyc(1);
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({imem_rd_out, valid_out, instruction_out} !== {2'b00, 14'h0000}) begin
            n_err++;
            $display("FAIL async_reset got rd=%b valid=%b instr=%h want rd=0 valid=0 instr=0000",
                     imem_rd_out, valid_out, instruction_out);
        end
    endtask

    task automatic test_sequential();
        logic [22:0] exp [3];
        exp[0] = {1'b1, 8'h00, 14'h100};
        exp[1] = {1'b1, 8'h01, 14'h101};
        exp[2] = {1'b1, 8'h02, 14'h102};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            n_vec++;
            if ({valid_out, pc_out, instruction_out} !== exp[i]) begin
                n_err++;
                $display("FAIL seq_%0d got v/pc/instr=%h want %h", i, {valid_out, pc_out, instruction_out}, exp[i]);
            end
        end
    endtask

    task automatic test_wait();
        do_reset();
        cyc(5);
        imem_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            n_vec++;
            if ({valid_out, imem_rd_out, imem_addr_out, pc_out} !== {2'b01, 8'h05, 8'h04}) begin
                n_err++;
                $display("FAIL wait_%0d got v=%b rd=%b addr=%h pc_out=%h want v=0 rd=1 addr=05 pc_out=04",
                         i, valid_out, imem_rd_out, imem_addr_out, pc_out);
            end
        end
        imem_ready_in = 1'b1;
        cyc(1);
        n_vec++;
        if ({valid_out, pc_out, instruction_out} !== {1'b1, 8'h05, 14'h105}) begin
            n_err++;
            $display("FAIL wait_done got v/pc/instr=%h want %h", {valid_out, pc_out, instruction_out}, {1'b1, 8'h05, 14'h105});
        end
    endtask

    task automatic test_stall();
        do_reset();
        cyc(7);
        stall_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            n_vec++;
            if ({valid_out, pc_out, instruction_out, imem_rd_out, imem_addr_out} !== {1'b1, 8'h06, 14'h106, 1'b0, 8'h08}) begin
                n_err++;
                $display("FAIL stall_hold_%0d got v=%b pc_out=%h instr=%h rd=%b addr=%h want 1 06 0106 0 08",
                         i, valid_out, pc_out, instruction_out, imem_rd_out, imem_addr_out);
            end
        end
        stall_in = 1'b0;
        cyc(1);
        n_vec++;
        if ({valid_out, pc_out, instruction_out, imem_rd_out, imem_addr_out} !== {1'b1, 8'h07, 14'h107, 1'b1, 8'h08}) begin
            n_err++;
            $display("FAIL stall_release got v=%b pc_out=%h instr=%h rd=%b addr=%h want 1 07 0107 1 08",
                     valid_out, pc_out, instruction_out, imem_rd_out, imem_addr_out);
        end
        cyc(1);
        n_vec++;
        if ({valid_out, pc_out, instruction_out} !== {1'b1, 8'h08, 14'h108}) begin
            n_err++;
            $display("FAIL stall_next got v/pc/instr=%h want %h", {valid_out, pc_out, instruction_out}, {1'b1, 8'h08, 14'h108});
        end
    endtask

    task automatic test_branch();
        do_reset();
        cyc(7);
        stall_in = 1'b1;
        cyc(1);
        branch_taken_in = 1'b1; branch_target_in = 8'h40;
        cyc(1);
        n_vec++;
        if ({valid_out, imem_rd_out, imem_addr_out} !== {2'b01, 8'h40}) begin
            n_err++;
            $display("FAIL branch_skid got v=%b rd=%b addr=%h want v=0 rd=1 addr=40", valid_out, imem_rd_out, imem_addr_out);
        end
        branch_taken_in = 1'b0; stall_in = 1'b0;
        cyc(1);
        n_vec++;
        if ({valid_out, pc_out, instruction_out} !== {1'b1, 8'h40, 14'h140}) begin
            n_err++;
            $display("FAIL branch_first got v/pc/instr=%h want %h", {valid_out, pc_out, instruction_out}, {1'b1, 8'h40, 14'h140});
        end
        branch_taken_in = 1'b1; branch_target_in = 8'h10;
        cyc(1);
        n_vec++;
        if ({valid_out, pc_out, imem_addr_out} !== {1'b0, 8'h40, 8'h10}) begin
            n_err++;
            $display("FAIL branch_discard got v=%b pc_out=%h addr=%h want v=0 pc_out=40 addr=10", valid_out, pc_out, imem_addr_out);
        end
        branch_taken_in = 1'b0;
        cyc(1);
        n_vec++;
        if ({valid_out, pc_out, instruction_out} !== {1'b1, 8'h10, 14'h110}) begin
            n_err++;
            $display("FAIL branch_fetch got v/pc/instr=%h want %h", {valid_out, pc_out, instruction_out}, {1'b1, 8'h10, 14'h110});
        end
    endtask

    task automatic test_wrap();
        do_reset();
        branch_taken_in = 1'b1; branch_target_in = 8'hFE;
        cyc(1);
        branch_taken_in = 1'b0;
        cyc(2);
        n_vec++;
        if ({valid_out, pc_out, instruction_out} !== {1'b1, 8'hFF, 14'h1FF}) begin
            n_err++;
            $display("FAIL wrap_ff got v/pc/instr=%h want %h", {valid_out, pc_out, instruction_out}, {1'b1, 8'hFF, 14'h1FF});
        end
        cyc(1);
        n_vec++;
        if ({valid_out, pc_out, instruction_out} !== {1'b1, 8'h00, 14'h100}) begin
            n_err++;
            $display("FAIL wrap_00 got v/pc/instr=%h want %h", {valid_out, pc_out, instruction_out}, {1'b1, 8'h00, 14'h100});
        end
    endtask

    task automatic test_halt();
        halt_word = 1'b1;
        do_reset();
        cyc(4);
        n_vec++;
        if ({valid_out, pc_out, instruction_out} !== {1'b1, 8'h03, 14'h3FFF}) begin
            n_err++;
            $display("FAIL halt_word got v/pc/instr=%h want %h", {valid_out, pc_out, instruction_out}, {1'b1, 8'h03, 14'h3FFF});
        end
`ifdef IF_HALT_DET_EN
        n_vec++;
        if ({halt_out, imem_rd_out} !== 2'b10) begin
            n_err++;
            $display("FAIL halt_enter got halt=%b rd=%b want halt=1 rd=0", halt_out, imem_rd_out);
        end
        branch_taken_in = 1'b1; branch_target_in = 8'h20;
        cyc(2);
        branch_taken_in = 1'b0;
        n_vec++;
        if ({halt_out, imem_rd_out, pc_out} !== {2'b10, 8'h03}) begin
            n_err++;
            $display("FAIL halt_branch got halt=%b rd=%b pc_out=%h want halt=1 rd=0 pc_out=03", halt_out, imem_rd_out, pc_out);
        end
        halt_word = 1'b0;
        do_reset();
        n_vec++;
        if ({halt_out, imem_rd_out, imem_addr_out} !== {2'b01, 8'h00}) begin
            n_err++;
            $display("FAIL halt_exit got halt=%b rd=%b addr=%h want halt=0 rd=1 addr=00", halt_out, imem_rd_out, imem_addr_out);
        end
`else
        n_vec++;
        if ({halt_out, imem_rd_out, imem_addr_out} !== {2'b01, 8'h04}) begin
            n_err++;
            $display("FAIL no_halt got halt=%b rd=%b addr=%h want halt=0 rd=1 addr=04", halt_out, imem_rd_out, imem_addr_out);
        end
        cyc(1);
        n_vec++;
        if ({valid_out, pc_out, instruction_out} !== {1'b1, 8'h04, 14'h104}) begin
            n_err++;
            $display("FAIL no_halt_next got v/pc/instr=%h want %h", {valid_out, pc_out, instruction_out}, {1'b1, 8'h04, 14'h104});
        end
        halt_word = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait();
        test_stall();
        test_branch();
        test_wrap();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/etapa_if.md
ETAPA_IF -- requirements
Module: etapa_if

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk is the clock and reset is the reset.
REQ-002 Parameter PC_W, default 8: width of the program counter and instruction-memory address.
REQ-003 Parameter INSTR_W, default 14: instruction width.
REQ-004 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-005 clk  in  1  clock; all state updates on posedge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 stall_in  in  1  downstream IF/ID stage cannot accept; hold outputs.
REQ-008 branch_taken_in  in  1  redirect fetch this cycle.
REQ-009 branch_target_in  in  PC_W  redirect address.
REQ-010 imem_rd_out  out  1  instruction-memory read request.
REQ-011 imem_addr_out  out  PC_W  read address; equals internal pc.
REQ-012 imem_data_in  in  INSTR_W  read data, valid when imem_ready_in=1.
REQ-013 imem_ready_in  in  1  memory completes request this cycle.
REQ-014 instruction_out  out  INSTR_W  fetched instruction to IF/ID register.
REQ-015 pc_out  out  PC_W  address of instruction_out.
REQ-016 valid_out  out  1  instruction_out holds a real instruction (0 = bubble).
REQ-017 halt_out  out  1  fetch halted (only with IF_HALT_DET_EN).

Function
REQ-018 States SHALL be FETCH, SKID, HALT; reset enters FETCH.
REQ-019 A transfer SHALL occur on a posedge where imem_rd_out=1 and imem_ready_in=1; imem_addr_out SHALL stay stable while imem_rd_out=1 and no transfer occurs.
REQ-020 In FETCH, imem_rd_out SHALL be 1 (combinational from state); in SKID and HALT it SHALL be 0.
REQ-021 FETCH, transfer, stall_in=0: instruction_out<=imem_data_in, pc_out<=pc, valid_out<=1, pc<=pc+1 (one-cycle latency, modulo 2^PC_W, 8'hFF wraps to 8'h00).
REQ-022 FETCH, no transfer, stall_in=0: valid_out<=0 (bubble); pc, instruction_out, pc_out hold.
REQ-023 stall_in=1: instruction_out, pc_out, valid_out SHALL hold in every state.
REQ-024 FETCH, transfer, stall_in=1: data and pc captured into one-entry skid buffer, pc<=pc+1, go SKID.
REQ-025 SKID, stall_in=0: skid contents moved to outputs with valid_out<=1, go FETCH; no instruction lost or duplicated.
REQ-026 branch_taken_in=1 SHALL take priority over stall and transfer: pc<=branch_target_in, valid_out<=0, skid emptied, any same-cycle transfer discarded, go FETCH.
REQ-027 Deasserting imem_rd_out without transfer SHALL be a cancel; memory must not respond to it.
REQ-028 Reset asserted mid-request SHALL abandon the request immediately (imem_rd_out drops asynchronously).

Reset
REQ-029 While reset=1: state FETCH, pc=RESET_PC, imem_rd_out=0, instruction_out=0, pc_out=0, valid_out=0, halt_out=0, skid empty.
REQ-030 First request SHALL issue on the first posedge after reset deasserts, with imem_addr_out=RESET_PC.

Configuration
REQ-031 With IF_HALT_DET_EN defined: an instruction of all ones (14'h3FFF) SHALL be delivered normally (valid_out=1), then state HALT, halt_out=1, no further requests; only reset leaves HALT (branch ignored).
REQ-032 Without IF_HALT_DET_EN: HALT state is not built, halt_out is tied 0, all-ones is an ordinary instruction.

Verification
REQ-033 Reset, memory always ready, data=addr+14'h100 -> instruction_out 14'h100,14'h101,14'h102 on consecutive cycles, pc_out 0,1,2, valid_out=1.
REQ-034 imem_ready_in low 3 cycles at address 5 -> valid_out=0 for 3 cycles, imem_addr_out held 5, then instruction for pc_out=5.
REQ-035 stall_in high 2 cycles coincident with transfer of address 7 -> outputs frozen, state SKID, on release pc_out=7 presented once, next fetch address 8.
REQ-036 branch_taken_in=1, target 8'h40, during stall with full skid -> valid_out=0, skid dropped, next imem_addr_out=8'h40.
REQ-037 PC at 8'hFF, continuous transfers -> pc_out 8'hFF then 8'h00.
REQ-038 IF_HALT_DET_EN defined, 14'h3FFF at address 3 -> pc_out=3 valid, halt_out=1, imem_rd_out=0 until reset; without macro fetching continues at 4.
